stage3_dmem_store_buffer: RTL and testbench



---
 rtl/stage3_dmem_store_buffer_pkg.sv | 47 ++++
 rtl/stage3_dmem_store_buffer_if.sv | 28 ++
 rtl/stage3_sb_fifo.sv | 74 +++++++
 rtl/stage3_dmem_store_buffer.sv | 135 +++++++++++++
 tb/tb_stage3_dmem_store_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage3_dmem_store_buffer_pkg.sv
// Store buffer shared types: entry layout, FSM states, helpers.
// Build option: STORE_BUFFER_COALESCE_EN (see top module).
package stage3_store_buffer_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_BE_W   = SB_DATA_W / 8;

  typedef logic [SB_ADDR_W-3:0] sb_waddr_t;
  typedef logic [SB_DATA_W-1:0] sb_data_t;
  typedef logic [SB_BE_W-1:0]   sb_be_t;

  typedef struct packed {
    sb_waddr_t waddr;
    sb_data_t  data;
    sb_be_t    be;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } sb_state_t;

  function automatic logic sb_word_hit(
    input logic [SB_ADDR_W-1:0] addr,
    input sb_waddr_t            waddr
  );
    return addr[SB_ADDR_W-1:2] == waddr;
  endfunction

  // Enabled lanes overwrite, lane enables accumulate.
  function automatic sb_entry_t sb_merge(
    input sb_entry_t old,
    input sb_data_t  wdata,
    input sb_be_t    be
  );
    sb_entry_t e;
    e = old;
    for (int l = 0; l < SB_BE_W; l++) begin
      if (be[l]) e.data[8*l +: 8] = wdata[8*l +: 8];
    end
    e.be = old.be | be;
    return e;
  endfunction

endpackage

// File: rtl/stage3_dmem_store_buffer_if.sv
// Simple data-bus handshake: request held until busy drops.
// Master drives the request, slave returns rdata/busy.
interface stage3_dmem_store_buffer_if
  import stage3_store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);

  logic                  ren;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;

  modport master (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );

  modport slave (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

endinterface

// File: rtl/stage3_sb_fifo.sv
// Store buffer storage: circular FIFO with wrap-bit pointers.
// Exposes head, tail (for merging) and per-slot valid/word address.
module stage3_sb_fifo
  import stage3_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  sb_entry_t              push_entry_i,
  input  logic                   pop_i,
  input  logic                   merge_i,
  input  sb_entry_t              merge_entry_i,
  output sb_entry_t              head_o,
  output sb_entry_t              tail_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       valid_o,
  output sb_waddr_t              waddr_o [DEPTH]
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW-1:0] tail_idx;
  sb_entry_t     mem_q [DEPTH];

  assign empty_o  = wptr_q == rptr_q;
  assign full_o   = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o  = wptr_q - rptr_q;
  assign tail_idx = wptr_q[AW-1:0] - 1'b1;
  assign head_o   = mem_q[rptr_q[AW-1:0]];
  assign tail_o   = mem_q[tail_idx];

  // Pointer advance on push/pop; both may happen together.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage: new entry at write pointer or merge into tail.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry_i;
    end else if (merge_i) begin
      mem_q[tail_idx] <= merge_entry_i;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs       = AW'(g) - rptr_q[AW-1:0];
    assign valid_o[g] = {1'b0, offs} < count_o;
    assign waddr_o[g] = mem_q[g].waddr;
  end

endmodule

// File: rtl/stage3_dmem_store_buffer.sv
// Posted-write store buffer between memory stage and data bus.
// Build option: STORE_BUFFER_COALESCE_EN merges same-word stores into tail.
module stage3_dmem_store_buffer
  import stage3_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  stage3_dmem_store_buffer_if.slave  cpu,
  stage3_dmem_store_buffer_if.master mem,
  input  logic                      flush_req,
  output logic                      drained,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  sb_state_t      state_q, state_d;
  sb_entry_t      head, tail, new_e, mrg_e;
  logic           empty, full;
  logic [DEPTH-1:0] valid;
  sb_waddr_t      waddr [DEPTH];

  logic is_st, is_ld, hit, can_merge;
  logic st_acc, push, merge, pop, ld_done;

  // Simultaneous read and write is resolved as a store.
  assign is_st = cpu.wen;
  assign is_ld = cpu.ren & ~cpu.wen;

  // Load word compared against every buffered entry, draining one included.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && sb_word_hit(cpu.addr, waddr[i])) hit = 1'b1;
    end
  end

  assign new_e = '{
    waddr: cpu.addr[SB_ADDR_W-1:2],
    data:  cpu.wdata,
    be:    cpu.byte_en
  };
  assign mrg_e = sb_merge(tail, cpu.wdata, cpu.byte_en);

`ifdef STORE_BUFFER_COALESCE_EN
  // Tail already on the bus must not change underneath the write.
  assign can_merge = ~empty &&
                     sb_word_hit(cpu.addr, tail.waddr) &&
                     !(state_q == DRAIN && occupancy == ONE);
`else
  assign can_merge = 1'b0;
`endif

  // Full is registered: a same-cycle pop frees the slot next cycle.
  assign st_acc  = is_st & (can_merge | ~full);
  assign push    = is_st & ~can_merge & ~full;
  assign merge   = is_st & can_merge;
  assign pop     = (state_q == DRAIN) & ~mem.busy;
  assign ld_done = (state_q == LOAD) & ~mem.busy;

  assign cpu.rdata = mem.rdata;
  assign cpu.busy  = RST | (is_st ? ~st_acc : (is_ld & ~ld_done));
  assign drained   = empty & (state_q == IDLE);

  stage3_sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (CLK),
    .rst_i         (RST),
    .push_i        (push),
    .push_entry_i  (new_e),
    .pop_i         (pop),
    .merge_i       (merge),
    .merge_entry_i (mrg_e),
    .head_o        (head),
    .tail_o        (tail),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (occupancy),
    .valid_o       (valid),
    .waddr_o       (waddr)
  );

  // Bus FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory-side request; loads win over draining.
  always_comb begin
    state_d     = state_q;
    mem.ren     = 1'b0;
    mem.wen     = 1'b0;
    mem.addr    = '0;
    mem.wdata   = '0;
    mem.byte_en = '0;
    unique case (state_q)
      IDLE: begin
        if (is_ld && !hit && !flush_req) begin
          state_d = LOAD;
        end else if (!empty) begin
          state_d = DRAIN;
        end
      end
      LOAD: begin
        mem.ren     = 1'b1;
        mem.addr    = cpu.addr;
        mem.byte_en = cpu.byte_en;
        if (!mem.busy) state_d = IDLE;
      end
      DRAIN: begin
        mem.wen     = 1'b1;
        mem.addr    = ADDR_W'({head.waddr, 2'b00});
        mem.wdata   = DATA_W'(head.data);
        mem.byte_en = head.be;
        if (!mem.busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read and write together from the memory stage is a protocol error.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_rw_excl: assert (!(cpu.ren && cpu.wen));
    end
  end

endmodule

// File: tb/tb_stage3_dmem_store_buffer.sv
// Directed bench for the store buffer with a write scoreboard.
// Optional build: STORE_BUFFER_COALESCE_EN.
module tb_stage3_dmem_store_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_req;
  logic       drained;
  logic [2:0] occupancy;

  always #5 clk = ~clk;

  stage3_dmem_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
  stage3_dmem_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  stage3_dmem_store_buffer #(.DEPTH(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .cpu       (cpu_if),
    .mem       (mem_if),
    .flush_req (flush_req),
    .drained   (drained),
    .occupancy (occupancy)
  );

`ifdef STORE_BUFFER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [256];
  logic [31:0] marr [256];
  int          checks = 0;
  int          failures = 0;
  int          wr_done;
  int          rd_issue_wr;
  logic [31:0] last_raddr;
  logic        mem_hold = 1'b0;
  logic [7:0]  mem_lat = 8'd0;
  logic [7:0]  wcnt;

  assign mem_if.busy  = (mem_if.ren | mem_if.wen) &
                        (mem_hold | (wcnt < mem_lat));
  assign mem_if.rdata = marr[mem_if.addr[9:2]];

  always @(posedge clk) begin
    if (rst || !(mem_if.ren || mem_if.wen) || !mem_if.busy) wcnt <= 8'd0;
    else wcnt <= wcnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  // Memory model and write scoreboard.
  initial begin
    logic        ren_prev;
    wr_t         e;
    logic [31:0] m;
    for (int i = 0; i < 256; i++) marr[i] = 32'hC0DE_0000 + i;
    wr_done     = 0;
    rd_issue_wr = -1;
    last_raddr  = '0;
    ren_prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mem_if.ren && !ren_prev) begin
        rd_issue_wr = wr_done;
        last_raddr  = mem_if.addr;
      end
      ren_prev = mem_if.ren;
      if (!rst && mem_if.wen && !mem_if.busy) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          m = lmask(e.be);
          check("wr_addr", mem_if.addr, e.a);
          check("wr_be", 32'(mem_if.byte_en), 32'(e.be));
          check("wr_data", mem_if.wdata & m, e.d & m);
        end
        for (int l = 0; l < 4; l++) begin
          if (mem_if.byte_en[l])
            marr[mem_if.addr[9:2]][8*l +: 8] = mem_if.wdata[8*l +: 8];
        end
        wr_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit coal,
                          output int waited);
    wr_t e;
    int  k;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) ref_mem[a[9:2]][8*l +: 8] = d[8*l +: 8];
    end
    if (coal && COAL && exp_wr.size() != 0) begin
      k = exp_wr.size() - 1;
      for (int l = 0; l < 4; l++) begin
        if (be[l]) exp_wr[k].d[8*l +: 8] = d[8*l +: 8];
      end
      exp_wr[k].be = exp_wr[k].be | be;
    end else begin
      e.a  = {a[31:2], 2'b00};
      e.d  = d;
      e.be = be;
      exp_wr.push_back(e);
    end
    cpu_if.wen     = 1'b1;
    cpu_if.addr    = a;
    cpu_if.wdata   = d;
    cpu_if.byte_en = be;
    waited = 0;
    @(negedge clk);
    while (cpu_if.busy && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("st_accept", 32'(cpu_if.busy), 32'd0);
    tick();
    cpu_if.wen = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] be);
    int n;
    exp_rd.push_back(ref_mem[a[9:2]]);
    cpu_if.ren     = 1'b1;
    cpu_if.addr    = a;
    cpu_if.byte_en = be;
    n = 0;
    @(negedge clk);
    while (cpu_if.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("ld_done", 32'(cpu_if.busy), 32'd0);
    check("ld_data", cpu_if.rdata, exp_rd.pop_front());
    tick();
    cpu_if.ren = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!drained && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(drained), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w, cnt, snap;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    rst            = 1'b1;
    flush_req      = 1'b0;
    cpu_if.ren     = 1'b0;
    cpu_if.wen     = 1'b0;
    cpu_if.addr    = '0;
    cpu_if.wdata   = '0;
    cpu_if.byte_en = '0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_busy", 32'(cpu_if.busy), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ren", 32'(mem_if.ren), 32'd0);
    check("rst_wen", 32'(mem_if.wen), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_drained", 32'(drained), 32'd1);
    check("rst_idle_busy", 32'(cpu_if.busy), 32'd0);
    tick();

    // Single store, memory busy 3 cycles
    mem_lat = 8'd3;
    do_store(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, w);
    check("s1_zero_wait", w, 0);
    @(negedge clk);
    check("s1_occ1", 32'(occupancy), 32'd1);
    check("s1_no_wen_yet", 32'(mem_if.wen), 32'd0);
    tick();
    @(negedge clk);
    check("s1_wen", 32'(mem_if.wen), 32'd1);
    check("s1_addr", mem_if.addr, 32'h100);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (mem_if.wen) cnt++;
      if (drained) break;
      @(negedge clk);
    end
    check("s1_wen_cycles", cnt, 4);
    check("s1_drained", 32'(drained), 32'd1);
    check("s1_occ0", 32'(occupancy), 32'd0);
    tick();

    // Fill with memory stalled; fifth store waits for a pop
    mem_hold = 1'b1;
    mem_lat  = 8'd0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h140 + 32'(4*i), 32'h1111_0000 + 32'(i), 4'hF, 1'b0, w);
      check("fill_zero_wait", w, 0);
    end
    @(negedge clk);
    check("fill_occ4", 32'(occupancy), 32'd4);
    tick();
    fork
      do_store(32'h150, 32'h2222_0005, 4'hF, 1'b0, w);
      begin
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_hold = 1'b0;
        @(negedge clk);
        check("fill_pop_vis", 32'(mem_if.wen & ~mem_if.busy), 32'd1);
        check("fill_full_busy", 32'(cpu_if.busy), 32'd1);
      end
    join
    check("st5_wait", w, 4);
    wait_drained("fill_drained");
    check("fill_sb_empty", exp_wr.size(), 0);

    // Load bypass to a different word, stall on same word
    mem_lat = 8'd2;
    snap = wr_done;
    do_store(32'h200, 32'h1234_5678, 4'hF, 1'b0, w);
    do_load(32'h204, 4'hF);
    check("byp_raddr", last_raddr, 32'h204);
    check("byp_before_drain", wr_done, snap);
    do_load(32'h202, 4'hC);
    check("hit_raddr", last_raddr, 32'h202);
    check("hit_after_drain", rd_issue_wr, snap + 1);
    wait_drained("hit_drained");

    // Fence: buffered stores drain before a held load
    mem_hold = 1'b1;
    mem_lat  = 8'd1;
    do_store(32'h110, 32'hA0A0_0001, 4'hF, 1'b0, w);
    do_store(32'h114, 32'hA0A0_0002, 4'hF, 1'b0, w);
    do_store(32'h118, 32'hA0A0_0003, 4'hF, 1'b0, w);
    @(negedge clk);
    check("fl_occ3", 32'(occupancy), 32'd3);
    tick();
    snap      = wr_done;
    flush_req = 1'b1;
    mem_hold  = 1'b0;
    fork
      do_load(32'h11C, 4'hF);
      begin
        cnt = 0;
        @(negedge clk);
        while (!drained && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        check("fl_drained", 32'(drained), 32'd1);
        check("fl_writes_done", wr_done, snap + 3);
        tick();
        flush_req = 1'b0;
      end
    join
    check("fl_load_after", rd_issue_wr, snap + 3);
    check("fl_raddr", last_raddr, 32'h11C);

    // Byte stores to one word behind an older draining entry
    mem_hold = 1'b1;
    mem_lat  = 8'd0;
    do_store(32'h3F0, 32'h5555_5555, 4'hF, 1'b0, w);
    do_store(32'h300, 32'hAAAA_AAAA, 4'b0001, 1'b0, w);
    do_store(32'h301, 32'hBBBB_BBBB, 4'b0010, 1'b1, w);
    check("co_zero_wait", w, 0);
    @(negedge clk);
    check("co_occ", 32'(occupancy), COAL ? 32'd2 : 32'd3);
    tick();
    mem_hold = 1'b0;
    wait_drained("co_drained");
    check("co_sb_empty", exp_wr.size(), 0);
    do_load(32'h300, 4'hF);

    // Reset while draining discards buffer contents
    mem_hold = 1'b1;
    do_store(32'h120, 32'h7777_0001, 4'hF, 1'b0, w);
    do_store(32'h124, 32'h7777_0002, 4'hF, 1'b0, w);
    @(negedge clk);
    check("rd_wen_pre", 32'(mem_if.wen), 32'd1);
    check("rd_occ2", 32'(occupancy), 32'd2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rd_busy_in_rst", 32'(cpu_if.busy), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rd_wen_post", 32'(mem_if.wen), 32'd0);
    check("rd_occ0", 32'(occupancy), 32'd0);
    check("rd_drained", 32'(drained), 32'd1);
    exp_wr.delete();
    tick();
    mem_hold = 1'b0;
    snap = wr_done;
    do_store(32'h128, 32'h8888_0001, 4'hF, 1'b0, w);
    wait_drained("post_rst_drained");
    check("post_rst_write", wr_done, snap + 1);

    check("end_wr_empty", exp_wr.size(), 0);
    check("end_rd_empty", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
